muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the SCPU execute stage. It takes both source operands straight from the register file read ports. It spends a fixed number of cycles computing, then presents a result and destination index to the register file write port. While it runs, the pipeline stalls on `busy`.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `CNT_W`, 5: iteration counter width, equal to log2(XLEN).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, reset asynchronous and active-high.
- `start`  in  1  request; sampled only while idle.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data`  in  32  operand A (dividend / multiplicand).
- `rs2_data`  in  32  operand B (divisor / multiplier).
- `rd`  in  5  destination register index.
- `busy`  out  1  high from the accept edge until `done` drops.
- `done`  out  1  one-cycle result-valid pulse.
- `result`  out  32  result; held stable until the next accept.
- `wb_rd`  out  5  captured destination index.
- `wb_en`  out  1  write enable toward the register file; equals `done && wb_rd != 0`.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: 32 iterations, counter 0..31.
  - FIX: sign correction and result select.
  - DONE: `done`=1 for one cycle, then returns to IDLE.
- Accept (IDLE && `start`):
  - capture `funct3`, `rd`, both operands, and the sign flags;
  - convert signed operands to magnitudes. Signed means MULH: A and B; MULHSU: A only; DIV/REM: both.
- Multiply: shift-add over the 64-bit product of magnitudes.
  - Negate the product in FIX if exactly one signed operand was negative.
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
- Divide: restoring division, one quotient bit per CALC cycle.
  - In FIX, negate the quotient if operand signs differ (DIV).
  - In FIX, negate the remainder if the dividend was negative (REM).
- Special cases are detected at accept. They bypass CALC and FIX and go straight to DONE with `result` loaded:
  - divide by zero (B=0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return A;
  - signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- `start` while `busy` is ignored. Operand, `funct3` and `rd` changes after accept have no effect.
- `rd`=0 completes normally, but `wb_en` stays 0, so x0 is never written.
- Reset values: state IDLE; `busy`, `done`, `wb_en` = 0; `result` = 0; `wb_rd` = 0; counter = 0.

## Timing
- Edge E0 samples `start`. `busy` rises after E0.
- E1..E32: CALC iterations. E32 moves the state to FIX.
- E33: result is registered and the state moves to DONE. `done`, `wb_en` and `result` are valid during the cycle after E33.
- E34: return to IDLE; `busy` and `done` fall.
  - A `start` sampled at E34 is accepted, giving back-to-back throughput of one op per 34 cycles.
- Special-case path: DONE is entered at E0, `done` is high during the cycle after E0, and the unit is back in IDLE at E1.
- Reset asserted at any point, including mid-CALC or in DONE:
  - all outputs clear immediately, without a clock edge;
  - the in-flight op is discarded and no `wb_en` pulse occurs;
  - the first edge after deassertion can accept a new `start`.

## Structure
- Shared package `muldiv_pkg`: funct3 encodings as named constants, state enum (IDLE/CALC/FIX/DONE), `XLEN`, and the divide-by-zero and overflow result constants.
- Single module. The datapath stays inline: a 64-bit accumulator/remainder register, a 32-bit operand register and a 5-bit counter. No sub-module is needed.

## Test plan
- MUL, A=7, B=0xFFFFFFFD, `rd`=5 → `result`=0xFFFFFFEB, `wb_rd`=5, `wb_en`=1; `done` is high exactly in the cycle after E33, and `busy` is high for 34 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH with the same operands → 0x00000000; MULHSU with the same operands → 0xFFFFFFFF.
- DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Every case in this line shows `done` in the cycle after E0.
- `start` held high with new operands during CALC → ignored and the original result is returned. Then MUL 3×4 with `rd`=0 → `result`=12, `done`=1, `wb_en`=0.
- `rst` pulsed asynchronously at CALC iteration 10 → `busy`, `done` and `result` go to 0 before the next edge, with no `wb_en`. Then MUL 2×3 → 6 with normal latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM states, special-case result constants.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [XLEN-1:0] DIV0_QUOT = '1;
  localparam logic [XLEN-1:0] OVF_QUOT  = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_REM   = '0;

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps,
// then a sign-fix cycle; divide-by-zero and signed overflow finish at accept.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [4:0]       rd,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [4:0]       wb_rd,
  output logic             wb_en
);
  import muldiv_pkg::*;

  state_t                state, state_d;
  logic [2*XLEN-1:0]     acc;
  logic [XLEN-1:0]       opr;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            f3_q;
  logic                  neg_a, neg_b;

  logic                  accept;
  logic                  in_neg_a, in_neg_b;
  logic [XLEN-1:0]       mag_a, mag_b;
  logic                  div_zero, div_ovf, special;
  logic [XLEN-1:0]       special_res;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_next;
  logic [XLEN:0]         div_top;
  logic [XLEN-1:0]       div_rem;
  logic [2*XLEN-1:0]     div_next;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       quot, rem;
  logic [XLEN-1:0]       fix_res;

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign wb_en = done && (wb_rd != '0);

  // DONE also accepts so back-to-back ops take 34 cycles each
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    in_neg_a    = signed_a(funct3) && rs1_data[XLEN-1];
    in_neg_b    = signed_b(funct3) && rs2_data[XLEN-1];
    mag_a       = in_neg_a ? -rs1_data : rs1_data;
    mag_b       = in_neg_b ? -rs2_data : rs2_data;
    div_zero    = funct3[2] && (rs2_data == '0);
    div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (rs1_data == OVF_QUOT) && (rs2_data == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? rs1_data : DIV0_QUOT;
    else if (div_ovf)
      special_res = funct3[1] ? OVF_REM : OVF_QUOT;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opr} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; the 33-bit top catches the shifted-out MSB
  always_comb begin
    div_top  = acc[2*XLEN-1:XLEN-1];
    div_rem  = div_top[XLEN-1:0] - opr;
    div_next = {acc[2*XLEN-2:0], 1'b0};
    if (div_top >= {1'b0, opr})
      div_next = {div_rem, acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod    = (neg_a ^ neg_b) ? -acc : acc;
    quot    = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem     = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_res = '0;
    case (f3_q)
      F3_MUL:                        fix_res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               fix_res = quot;
      default:                       fix_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == '1) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = accept ? (special ? ST_DONE : ST_CALC) : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      opr    <= '0;
      cnt    <= '0;
      f3_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      result <= '0;
      wb_rd  <= '0;
    end else if (accept) begin
      f3_q  <= funct3;
      wb_rd <= rd;
      neg_a <= in_neg_a;
      neg_b <= in_neg_b;
      cnt   <= '0;
      if (funct3[2]) begin
        opr <= mag_b;
        acc <= {{XLEN{1'b0}}, mag_a};
      end else begin
        opr <= mag_a;
        acc <= {{XLEN{1'b0}}, mag_b};
      end
      if (special)
        result <= special_res;
    end else if (state == ST_CALC) begin
      cnt <= cnt + 1'b1;
      acc <= f3_q[2] ? div_next : mul_next;
    end else if (state == ST_FIX) begin
      result <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: table of ops with expected result
// and latency, plus start-while-busy and mid-operation reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
    .busy(busy), .done(done), .result(result), .wb_rd(wb_rd), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic        exp_wb;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Applies one op, scrambles inputs after accept, counts negedges until done.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    int busy_n;
    int early_wb;
    n = 0; busy_n = 0; early_wb = 0;
    @(negedge clk);
    funct3 = v.f3; rs1_data = v.a; rs2_data = v.b; rd = v.rd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd = 5'($urandom);
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (!done && wb_en) early_wb++;
    end while (!done && n < 100);
    chk({tag, "_latency"}, 32'(n), 32'(v.lat));
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(v.lat));
    chk({tag, "_result"}, result, v.exp_res);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
    chk({tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, v.exp_wb});
    chk({tag, "_early_wb"}, 32'(early_wb), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, {30'd0, busy, done}, 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    int n;
    vec_t v;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1, 34};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 1'b1, 34};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 1'b1, 34};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b1, 34};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          5'd4,  32'hFFFF_FFFD, 1'b1, 34};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          5'd6,  32'hFFFF_FFFF, 1'b1, 34};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,          5'd7,  32'd14,        1'b1, 34};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,          5'd8,  32'd2,         1'b1, 34};
    vecs[8]  = '{3'b101, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF, 1'b1, 1};
    vecs[9]  = '{3'b111, 32'd5,          32'd0,          5'd10, 32'd5,         1'b1, 1};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1, 1};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1'b1, 1};
    vecs[12] = '{3'b000, 32'd3,          32'd4,          5'd0,  32'd12,        1'b0, 34};

    #1;
    chk("reset_outputs", {result[31:0]}, 32'd0);
    chk("reset_flags", {24'd0, wb_rd, busy, done, wb_en}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i], $sformatf("v%0d", i));

    // start held high with different operands during CALC
    @(negedge clk);
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd13; start = 1'b1;
    @(posedge clk);
    #1;
    funct3 = 3'b000; rs1_data = 32'd55; rs2_data = 32'd3; rd = 5'd20;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_start_latency", 32'(n), 32'd34);
    chk("hold_start_result", result, 32'd14);
    chk("hold_start_wb_rd", {27'd0, wb_rd}, 32'd13);
    @(posedge clk);
    #1;
    chk("hold_start_idle", {30'd0, busy, done}, 32'd0);

    run_op(vecs[12], "rd0_mul");

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd9; rd = 5'd14; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_flags", {24'd0, wb_rd, busy, done, wb_en}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_wb_en", {31'd0, wb_en}, 32'd0);
    end
    rst = 1'b0;
    v = '{3'b000, 32'd2, 32'd3, 5'd15, 32'd6, 1'b1, 34};
    run_op(v, "post_rst_mul");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
